pulse_trigger_bank: RTL

- Multi-channel, parametrised successor to the single pulse/trigger generators.
- Each channel is either a gated free-running pulse train or a key-driven trigger: one-shot or retriggerable.
- Pulse width and period are run-time programmable.
- Sits between the clock module and the lab benches or counters that consume pulses and debounced key events. All channels share one clock and one configuration bus.

---
 rtl/pulse_trigger_bank.sv | 87 ++++++++
 1 files changed

// File: rtl/pulse_trigger_bank.sv
// Multi-channel pulse/trigger generator: each channel is a gated free-running
// pulse train or a key-triggered one-shot/retriggerable pulse, sharing one config bus.
module pulse_trigger_bank #(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned CNT_W    = 8
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                enable,
   input  logic [1:0]          mode,
   input  logic [CNT_W-1:0]    width,
   input  logic [CNT_W-1:0]    period,
   input  logic [CHANNELS-1:0] key,
   output logic [CHANNELS-1:0] pulse,
   output logic [CHANNELS-1:0] busy
);

   typedef enum logic [1:0] {
      MODE_OFF     = 2'b00,
      MODE_PULSE   = 2'b01,
      MODE_ONESHOT = 2'b10,
      MODE_RETRIG  = 2'b11
   } mode_e;

   mode_e                          mode_c;
   mode_e                          mode_q;
   logic [CHANNELS-1:0]            key_q;
   logic [CHANNELS-1:0]            rise_c;
   logic [CNT_W-1:0]               phase;
   logic [CNT_W-1:0]               phase_nx;
   logic [CHANNELS-1:0][CNT_W-1:0] cnt;
   logic [CHANNELS-1:0][CNT_W-1:0] cnt_nx;
   logic [CHANNELS-1:0]            pulse_nx;
   logic [CHANNELS-1:0]            busy_nx;

   // Next-state: everything collapses to zero when disabled, OFF, or on a mode change
   always_comb begin
      mode_c   = mode_e'(mode);
      rise_c   = key & ~key_q;
      phase_nx = '0;
      cnt_nx   = '0;
      pulse_nx = '0;
      busy_nx  = '0;
      if (enable && (mode_c == mode_q)) begin
         case (mode_c)
            MODE_PULSE: begin
               // period=0 parks the phase at 0 with the output low
               if (period != '0) begin
                  phase_nx = (phase >= period - CNT_W'(1)) ? '0 : phase + CNT_W'(1);
                  if (phase < width) pulse_nx = key;
               end
            end
            MODE_ONESHOT, MODE_RETRIG: begin
               for (int unsigned i = 0; i < CHANNELS; i++) begin
                  if (rise_c[i] && (!busy[i] || (mode_c == MODE_RETRIG)))
                     cnt_nx[i] = width;
                  else if (cnt[i] != '0)
                     cnt_nx[i] = cnt[i] - CNT_W'(1);
                  busy_nx[i]  = (cnt_nx[i] != '0);
                  pulse_nx[i] = busy_nx[i];
               end
            end
            default: ;
         endcase
      end
   end

   // Key history and last mode track every cycle so re-enabling never fakes an edge
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         key_q  <= '0;
         mode_q <= MODE_OFF;
         phase  <= '0;
         cnt    <= '0;
         pulse  <= '0;
         busy   <= '0;
      end else begin
         key_q  <= key;
         mode_q <= mode_c;
         phase  <= phase_nx;
         cnt    <= cnt_nx;
         pulse  <= pulse_nx;
         busy   <= busy_nx;
      end
   end

endmodule
